// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with ID-stage branch
// resolution, hazard detection and saturating debug counters.
module if_id_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction_if,
  input  logic [31:0]      NextPC_if,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic             MemRead_ex,
  input  logic             RegWrite_ex,
  input  logic [4:0]       WriteReg_ex,
  input  logic             MemRead_mem,
  input  logic [4:0]       WriteReg_mem,
  output logic [31:0]      Instruction_id,
  output logic [31:0]      NextPC_id,
  output logic             Z,
  output logic             J,
  output logic             JR,
  output logic             PC_IFWrite,
  output logic [31:0]      BranchAddr,
  output logic [31:0]      JumpAddr,
  output logic [31:0]      JrAddr,
  output logic             ID_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [31:0]      r_instr;
  logic [31:0]      r_npc;
  logic             r_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [15:0] w_imm;
  logic        w_rtype;
  logic        w_beq;
  logic        w_bne;
  logic        w_j;
  logic        w_jal;
  logic        w_jr;
  logic        w_ialu;
  logic        w_load;
  logic        w_store;
  logic        w_cmp;
  logic        w_uses_rs;
  logic        w_uses_rt;
  logic        w_ex_rs;
  logic        w_ex_rt;
  logic        w_mem_rs;
  logic        w_mem_rt;
  logic        w_load_use;
  logic        w_br_hz;
  logic        w_stall;
  logic        w_z;
  logic        w_j_sel;
  logic        w_jr_sel;
  logic        w_redirect;

  assign w_op    = r_instr[31:26];
  assign w_funct = r_instr[5:0];
  assign w_rs    = r_instr[25:21];
  assign w_rt    = r_instr[20:16];
  assign w_imm   = r_instr[15:0];

  // Opcode class decode; a squashed slot decodes to nothing.
  always_comb begin
    w_rtype = 1'b0;
    w_beq   = 1'b0;
    w_bne   = 1'b0;
    w_j     = 1'b0;
    w_jal   = 1'b0;
    w_ialu  = 1'b0;
    w_load  = 1'b0;
    w_store = 1'b0;
    if (r_valid) begin
      unique case (1'b1)
        w_op == 6'h00:      w_rtype = 1'b1;
        w_op == 6'h02:      w_j     = 1'b1;
        w_op == 6'h03:      w_jal   = 1'b1;
        w_op == 6'h04:      w_beq   = 1'b1;
        w_op == 6'h05:      w_bne   = 1'b1;
        w_op[5:3] == 3'b001: w_ialu  = 1'b1;
        w_op[5:3] == 3'b100: w_load  = 1'b1;
        w_op[5:3] == 3'b101: w_store = 1'b1;
        default: ;
      endcase
    end
  end

  assign w_jr      = w_rtype && (w_funct == 6'h08);
  assign w_cmp     = w_beq | w_bne;
  assign w_uses_rs = w_rtype | w_cmp | w_ialu | w_load | w_store;
  assign w_uses_rt = w_rtype | w_cmp | w_store;

  assign w_ex_rs  = (WriteReg_ex != 5'd0) && (WriteReg_ex == w_rs);
  assign w_ex_rt  = (WriteReg_ex != 5'd0) && (WriteReg_ex == w_rt);
  assign w_mem_rs = (WriteReg_mem != 5'd0) && (WriteReg_mem == w_rs);
  assign w_mem_rt = (WriteReg_mem != 5'd0) && (WriteReg_mem == w_rt);

  assign w_load_use = MemRead_ex &&
                      ((w_uses_rs && w_ex_rs) ||
                       (w_uses_rt && w_ex_rt));

  // Branches compare in ID, so any in-flight producer must land first.
  assign w_br_hz = (w_cmp | w_jr) &&
                   ((RegWrite_ex && (w_ex_rs || (w_cmp && w_ex_rt))) ||
                    (MemRead_mem && (w_mem_rs || (w_cmp && w_mem_rt))));

  assign w_stall = w_load_use | w_br_hz;

  assign w_z = !w_stall &&
               ((w_beq && (rs_data == rt_data)) ||
                (w_bne && (rs_data != rt_data)));
  assign w_j_sel    = !w_stall && (w_j | w_jal);
  assign w_jr_sel   = !w_stall && w_jr;
  assign w_redirect = w_z | w_j_sel | w_jr_sel;

  // IF/ID register: stall holds, redirect squashes, else advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= 32'd0;
      r_npc   <= 32'd0;
      r_valid <= 1'b0;
    end else if (w_stall) begin
      r_instr <= r_instr;
      r_npc   <= r_npc;
      r_valid <= r_valid;
    end else if (w_redirect) begin
      r_instr <= 32'd0;
      r_npc   <= NextPC_if;
      r_valid <= 1'b0;
    end else begin
      r_instr <= Instruction_if;
      r_npc   <= NextPC_if;
      r_valid <= 1'b1;
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign Instruction_id = r_instr;
  assign NextPC_id      = r_npc;
  assign Z              = w_z;
  assign J              = w_j_sel;
  assign JR             = w_jr_sel;
  assign PC_IFWrite     = !w_stall;
  assign ID_bubble      = w_stall;
  assign BranchAddr     = r_npc + {{14{w_imm[15]}}, w_imm, 2'b00};
  assign JumpAddr       = {r_npc[31:28], r_instr[25:0], 2'b00};
  assign JrAddr         = rs_data;
  assign stall_count    = r_stall_cnt;
  assign flush_count    = r_flush_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: vector table with scoreboard queue, plus
// hand sequences for reset, squash, stalls and saturation.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction_if;
  logic [31:0] NextPC_if;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        MemRead_ex;
  logic        RegWrite_ex;
  logic [4:0]  WriteReg_ex;
  logic        MemRead_mem;
  logic [4:0]  WriteReg_mem;
  logic [31:0] Instruction_id;
  logic [31:0] NextPC_id;
  logic        Z;
  logic        J;
  logic        JR;
  logic        PC_IFWrite;
  logic [31:0] BranchAddr;
  logic [31:0] JumpAddr;
  logic [31:0] JrAddr;
  logic        ID_bubble;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  if_id_stage #(.CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .Instruction_if (Instruction_if),
    .NextPC_if      (NextPC_if),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .MemRead_ex     (MemRead_ex),
    .RegWrite_ex    (RegWrite_ex),
    .WriteReg_ex    (WriteReg_ex),
    .MemRead_mem    (MemRead_mem),
    .WriteReg_mem   (WriteReg_mem),
    .Instruction_id (Instruction_id),
    .NextPC_id      (NextPC_id),
    .Z              (Z),
    .J              (J),
    .JR             (JR),
    .PC_IFWrite     (PC_IFWrite),
    .BranchAddr     (BranchAddr),
    .JumpAddr       (JumpAddr),
    .JrAddr         (JrAddr),
    .ID_bubble      (ID_bubble),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        mre;
    logic        rwe;
    logic [4:0]  wre;
    logic        mrm;
    logic [4:0]  wrm;
    logic        z;
    logic        j;
    logic        jr;
    logic        st;
    logic [1:0]  ak;
    logic [31:0] ad;
  } vec_t;

  typedef struct {
    logic        z;
    logic        j;
    logic        jr;
    logic        pcw;
    logic        bub;
    logic [1:0]  ak;
    logic [31:0] ad;
    logic [31:0] after;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(
    input logic [31:0] ins, npc, rs, rt,
    input logic mre, rwe, input logic [4:0] wre,
    input logic mrm, input logic [4:0] wrm,
    input logic z, j, jr, st,
    input logic [1:0] ak, input logic [31:0] ad);
    vec_t v;
    v.instr = ins; v.npc = npc; v.rs = rs; v.rt = rt;
    v.mre = mre; v.rwe = rwe; v.wre = wre;
    v.mrm = mrm; v.wrm = wrm;
    v.z = z; v.j = j; v.jr = jr; v.st = st;
    v.ak = ak; v.ad = ad;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clr();
    rs_data = 0; rt_data = 0;
    MemRead_ex = 0; RegWrite_ex = 0; WriteReg_ex = 0;
    MemRead_mem = 0; WriteReg_mem = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr();
    Instruction_if = 0; NextPC_if = 0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load(input logic [31:0] ins,
                      input logic [31:0] npc);
    @(negedge clk);
    clr();
    Instruction_if = ins; NextPC_if = npc;
    @(posedge clk);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    exp_t g;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    Instruction_if = 0; NextPC_if = 0;
    clr();

    // ins npc rs rt | mre rwe wre mrm wrm | z j jr st | ak addr
    vecs.push_back(mk(32'h10220003, 32'h14, 5, 5, 0,0,0, 0,0, 1,0,0,0, 1, 32'h20));
    vecs.push_back(mk(32'h10220003, 32'h14, 5, 6, 0,0,0, 0,0, 0,0,0,0, 1, 32'h20));
    vecs.push_back(mk(32'h14220003, 32'h14, 5, 6, 0,0,0, 0,0, 1,0,0,0, 1, 32'h20));
    vecs.push_back(mk(32'h14220003, 32'h14, 5, 5, 0,0,0, 0,0, 0,0,0,0, 1, 32'h20));
    vecs.push_back(mk(32'h08000040, 32'h80000008, 0, 0, 0,0,0, 0,0, 0,1,0,0, 2, 32'h80000100));
    vecs.push_back(mk(32'h0C000040, 32'h10000000, 0, 0, 0,0,0, 0,0, 0,1,0,0, 2, 32'h10000100));
    vecs.push_back(mk(32'h03E00008, 32'h0, 32'h44, 0, 0,0,0, 0,0, 0,0,1,0, 3, 32'h44));
    vecs.push_back(mk(32'h1000FFFF, 32'h0, 0, 0, 0,0,0, 0,0, 1,0,0,0, 1, 32'hFFFFFFFC));
    vecs.push_back(mk(32'h00652020, 32'h8, 0, 0, 1,1,3, 0,0, 0,0,0,1, 0, 0));
    vecs.push_back(mk(32'h00652020, 32'h8, 0, 0, 1,1,5, 0,0, 0,0,0,1, 0, 0));
    vecs.push_back(mk(32'h00052020, 32'h8, 0, 0, 1,1,0, 0,0, 0,0,0,0, 0, 0));
    vecs.push_back(mk(32'h10000003, 32'h40, 0, 0, 0,1,0, 1,0, 1,0,0,0, 1, 32'h4C));
    vecs.push_back(mk(32'h10220003, 32'h14, 5, 5, 0,1,2, 0,0, 0,0,0,1, 1, 32'h20));
    vecs.push_back(mk(32'h03E00008, 32'h0, 32'h44, 0, 0,0,0, 1,31, 0,0,0,1, 3, 32'h44));
    vecs.push_back(mk(32'h03E00008, 32'h0, 32'h44, 0, 0,1,31, 0,0, 0,0,0,1, 3, 32'h44));
    vecs.push_back(mk(32'h00652020, 32'h8, 0, 0, 0,1,3, 0,0, 0,0,0,0, 0, 0));
    vecs.push_back(mk(32'hAC650000, 32'h8, 0, 0, 1,1,5, 0,0, 0,0,0,1, 0, 0));
    vecs.push_back(mk(32'h20E60001, 32'h8, 0, 0, 1,1,6, 0,0, 0,0,0,0, 0, 0));
    vecs.push_back(mk(32'h20E60001, 32'h8, 0, 0, 1,1,7, 0,0, 0,0,0,1, 0, 0));
    vecs.push_back(mk(32'h14220003, 32'h14, 5, 6, 0,0,0, 1,2, 0,0,0,1, 1, 32'h20));

    // Reset with clock running, then first fetch appears.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    Instruction_if = 32'h20010005; NextPC_if = 32'h4;
    #1;
    chk("rst_instr", Instruction_id, 32'h0);
    chk("rst_npc", NextPC_id, 32'h0);
    chk("rst_scnt", {16'd0, stall_count}, 32'h0);
    chk("rst_fcnt", {16'd0, flush_count}, 32'h0);
    chk("rst_zjjr", {29'd0, Z, J, JR}, 32'h0);
    chk("rst_pcw", {31'd0, PC_IFWrite}, 32'h1);
    chk("rst_bub", {31'd0, ID_bubble}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_first", Instruction_id, 32'h20010005);
    chk("rst_first_npc", NextPC_id, 32'h4);

    // Table: each vector from a clean reset, one evaluated cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_reset();
      load(v.instr, v.npc);
      @(negedge clk);
      rs_data = v.rs; rt_data = v.rt;
      MemRead_ex = v.mre; RegWrite_ex = v.rwe; WriteReg_ex = v.wre;
      MemRead_mem = v.mrm; WriteReg_mem = v.wrm;
      Instruction_if = 32'hDEADBEEF; NextPC_if = v.npc + 4;
      e.z = v.z; e.j = v.j; e.jr = v.jr;
      e.pcw = !v.st; e.bub = v.st;
      e.ak = v.ak; e.ad = v.ad;
      e.after = v.st ? v.instr :
                ((v.z | v.j | v.jr) ? 32'h0 : 32'hDEADBEEF);
      e.scnt = {15'd0, v.st};
      e.fcnt = {15'd0, v.z | v.j | v.jr};
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      chk($sformatf("v%0d_Z", i), {31'd0, Z}, {31'd0, g.z});
      chk($sformatf("v%0d_J", i), {31'd0, J}, {31'd0, g.j});
      chk($sformatf("v%0d_JR", i), {31'd0, JR}, {31'd0, g.jr});
      chk($sformatf("v%0d_pcw", i), {31'd0, PC_IFWrite}, {31'd0, g.pcw});
      chk($sformatf("v%0d_bub", i), {31'd0, ID_bubble}, {31'd0, g.bub});
      case (g.ak)
        2'd1: chk($sformatf("v%0d_baddr", i), BranchAddr, g.ad);
        2'd2: chk($sformatf("v%0d_jaddr", i), JumpAddr, g.ad);
        2'd3: chk($sformatf("v%0d_jraddr", i), JrAddr, g.ad);
        default: ;
      endcase
      @(posedge clk); #1;
      chk($sformatf("v%0d_next", i), Instruction_id, g.after);
      chk($sformatf("v%0d_scnt", i), {16'd0, stall_count}, {16'd0, g.scnt});
      chk($sformatf("v%0d_fcnt", i), {16'd0, flush_count}, {16'd0, g.fcnt});
    end

    // beq taken: one squashed slot, then the target fetch lands.
    do_reset();
    load(32'h10220003, 32'h14);
    @(negedge clk);
    rs_data = 5; rt_data = 5;
    Instruction_if = 32'h12345678; NextPC_if = 32'h18;
    #1;
    chk("beq_Z", {31'd0, Z}, 32'h1);
    chk("beq_addr", BranchAddr, 32'h20);
    @(posedge clk); #1;
    chk("beq_squash", Instruction_id, 32'h0);
    chk("beq_sq_npc", NextPC_id, 32'h18);
    chk("beq_fcnt", {16'd0, flush_count}, 32'h1);
    @(negedge clk);
    #1;
    chk("beq_sq_noZ", {29'd0, Z, J, JR}, 32'h0);
    Instruction_if = 32'h20010005; NextPC_if = 32'h24;
    @(posedge clk); #1;
    chk("beq_target", Instruction_id, 32'h20010005);
    chk("beq_fcnt2", {16'd0, flush_count}, 32'h1);

    // Load-use: one stall cycle, IF/ID held.
    do_reset();
    load(32'h00652020, 32'h8);
    @(negedge clk);
    MemRead_ex = 1; RegWrite_ex = 1; WriteReg_ex = 3;
    Instruction_if = 32'h00A63020; NextPC_if = 32'hC;
    #1;
    chk("lu_pcw", {31'd0, PC_IFWrite}, 32'h0);
    chk("lu_bub", {31'd0, ID_bubble}, 32'h1);
    @(posedge clk); #1;
    chk("lu_hold", Instruction_id, 32'h00652020);
    chk("lu_scnt", {16'd0, stall_count}, 32'h1);
    @(negedge clk);
    MemRead_ex = 0; RegWrite_ex = 0; WriteReg_ex = 0;
    MemRead_mem = 1; WriteReg_mem = 3;
    #1;
    chk("lu_pcw2", {31'd0, PC_IFWrite}, 32'h1);
    chk("lu_bub2", {31'd0, ID_bubble}, 32'h0);
    @(posedge clk); #1;
    chk("lu_adv", Instruction_id, 32'h00A63020);
    chk("lu_scnt2", {16'd0, stall_count}, 32'h1);

    // Branch right after a load: two stalls, then resolve.
    do_reset();
    load(32'h10400003, 32'h30);
    @(negedge clk);
    MemRead_ex = 1; RegWrite_ex = 1; WriteReg_ex = 2;
    Instruction_if = 32'hDEADBEEF; NextPC_if = 32'h34;
    #1;
    chk("bl_pcw1", {31'd0, PC_IFWrite}, 32'h0);
    chk("bl_zjjr1", {29'd0, Z, J, JR}, 32'h0);
    @(negedge clk);
    MemRead_ex = 0; RegWrite_ex = 0; WriteReg_ex = 0;
    MemRead_mem = 1; WriteReg_mem = 2;
    #1;
    chk("bl_pcw2", {31'd0, PC_IFWrite}, 32'h0);
    chk("bl_zjjr2", {29'd0, Z, J, JR}, 32'h0);
    chk("bl_bub2", {31'd0, ID_bubble}, 32'h1);
    @(posedge clk); #1;
    chk("bl_hold", Instruction_id, 32'h10400003);
    chk("bl_scnt", {16'd0, stall_count}, 32'h2);
    @(negedge clk);
    MemRead_mem = 0; WriteReg_mem = 0;
    #1;
    chk("bl_Z", {31'd0, Z}, 32'h1);
    chk("bl_addr", BranchAddr, 32'h3C);
    @(posedge clk); #1;
    chk("bl_squash", Instruction_id, 32'h0);
    chk("bl_fcnt", {16'd0, flush_count}, 32'h1);
    chk("bl_scnt2", {16'd0, stall_count}, 32'h2);

    // Reset mid-redirect: redirect gone, fetch resumes normally.
    do_reset();
    load(32'h10220003, 32'h14);
    @(negedge clk);
    rs_data = 5; rt_data = 5;
    #1;
    chk("rr_Z", {31'd0, Z}, 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("rr_Z0", {31'd0, Z}, 32'h0);
    chk("rr_instr", Instruction_id, 32'h0);
    @(negedge clk);
    Instruction_if = 32'h20010005; NextPC_if = 32'h4;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rr_load", Instruction_id, 32'h20010005);
    chk("rr_fcnt", {16'd0, flush_count}, 32'h0);

    // Reset mid-stall: counter cleared, invalid slot ignores hazard.
    do_reset();
    load(32'h00652020, 32'h8);
    @(negedge clk);
    MemRead_ex = 1; WriteReg_ex = 3;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rs_scnt1", {16'd0, stall_count}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rs_scnt0", {16'd0, stall_count}, 32'h0);
    chk("rs_pcw", {31'd0, PC_IFWrite}, 32'h1);
    chk("rs_instr", Instruction_id, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Stall counter saturates at all-ones.
    do_reset();
    load(32'h00652020, 32'h8);
    @(negedge clk);
    MemRead_ex = 1; WriteReg_ex = 3;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", {16'd0, stall_count}, 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_ffff", {16'd0, stall_count}, 32'hFFFF);
    chk("sat_hold", Instruction_id, 32'h00652020);
    @(negedge clk);
    clr();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Pipeline register and branch-resolution unit sitting directly downstream of the instruction-fetch stage in the 32-bit MIPS core. It captures the fetched instruction and PC+4 into the IF/ID register, decodes control transfers (beq, bne, j, jal, jr) in the ID stage, and drives the fetch stage's PC-select inputs (Z, J, JR, PC_IFWrite) and target addresses. It also detects load-use and branch-operand hazards, stalls fetch, squashes wrong-path instructions, and keeps saturating stall/flush counters for debug.

## Interface
- CNT_W, 16, width of the stall and flush event counters
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- Instruction_if  in  32  instruction from fetch
- NextPC_if  in  32  PC+4 from fetch
- rs_data  in  32  rs operand, already forwarded, for the instruction in ID
- rt_data  in  32  rt operand, already forwarded, for the instruction in ID
- MemRead_ex, RegWrite_ex  in  1 each  EX-stage instruction is a load / writes a register
- WriteReg_ex  in  5  EX-stage destination register
- MemRead_mem  in  1  MEM-stage instruction is a load
- WriteReg_mem  in  5  MEM-stage destination register
- Instruction_id  out  32  IF/ID instruction; 0 (NOP) when invalid
- NextPC_id  out  32  IF/ID PC+4
- Z, J, JR  out  1 each  one-hot PC select to fetch: branch taken / j or jal / jr
- PC_IFWrite  out  1  0 freezes fetch PC
- BranchAddr, JumpAddr, JrAddr  out  32 each  redirect targets
- ID_bubble  out  1  ID/EX must load a bubble this cycle
- stall_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- IF/ID register: Instruction_id, NextPC_id, valid_id. Each posedge: if stall, hold; else if redirect, load Instruction_id=0, NextPC_id=NextPC_if, valid_id=0; else load Instruction_if, NextPC_if, valid_id=1.
- Decode, gated by valid_id: beq op=6'h04, bne op=6'h05, j op=6'h02, jal op=6'h03, jr op=6'h00 with funct=6'h08.
- Source use: uses_rs for R-type, beq, bne, I-type ALU and loads/stores; uses_rt for R-type, beq, bne, stores. Register 0 never causes a hazard.
- Load-use hazard: MemRead_ex, WriteReg_ex!=0, and WriteReg_ex matches a used source.
- Branch-operand hazard (beq, bne, jr only): RegWrite_ex and WriteReg_ex matches rs, or rt for beq/bne; or MemRead_mem and WriteReg_mem matches the same registers.
- stall = either hazard. On stall: PC_IFWrite=0, ID_bubble=1, and Z=J=JR=0.
- Without stall:
  - Z=1 for beq with rs_data==rt_data, or bne with rs_data!=rt_data.
  - J=1 for j or jal.
  - JR=1 for jr.
  - redirect = Z|J|JR.
- Z, J, JR are never more than one high at a time.
- Targets, all computed from the IF/ID contents:
  - BranchAddr = NextPC_id + (sign-extended imm[15:0] shifted left 2), 32-bit, wraps modulo 2^32.
  - JumpAddr = {NextPC_id[31:28], instr[25:0], 2'b00}.
  - JrAddr = rs_data.
- Counters: stall_count increments on every stalled cycle; flush_count increments on every redirect cycle. Both saturate at all-ones and never wrap.

## Timing
- Reset asserted (asynchronous): Instruction_id=0, NextPC_id=0, valid_id=0, stall_count=0, flush_count=0.
- During reset, outputs follow from that state: Z=J=JR=0, PC_IFWrite=1, ID_bubble=0.
- Reset asserted mid-stall or mid-redirect clears state immediately; no pending redirect survives reset.
- All control outputs and target addresses are combinational from IF/ID state and the hazard inputs, valid in the same cycle. Fetch samples them at the next posedge.
- Redirect penalty: exactly one squashed slot, the instruction fetched during the redirect cycle.
- Stall holds IF/ID for exactly the cycles the hazard persists:
  - load-use: 1 cycle;
  - branch operand produced by an ALU op in EX: 1 cycle;
  - branch operand produced by a load in EX: 2 cycles (EX, then MEM).
- Stall and redirect in the same cycle: stall wins, redirect is suppressed until the hazard clears.
- A squashed slot (valid_id=0) never stalls and never redirects.

## Test plan
- Reset sequence: assert reset with clk running, then release. Required: Instruction_id=0 and both counters 0 during reset; the instruction at fetch PC 0 appears in Instruction_id one posedge after release.
- beq redirect: beq $1,$2,+3 at NextPC_id=0x14 with rs_data=rt_data=5. Required: Z=1, BranchAddr=0x20, next Instruction_id=0, flush_count=1. Same setup with rt_data=6: Z=0, no flush.
- Jumps: j 0x0000040 at NextPC_id=0x80000008 gives J=1, JumpAddr=0x80000100. jr $31 with rs_data=0x44 gives JR=1, JrAddr=0x44.
- Load-use: lw $3 in EX (MemRead_ex=1, WriteReg_ex=3) and add $4,$3,$5 in ID. Required: PC_IFWrite=0 and ID_bubble=1 for exactly one cycle, IF/ID held, stall_count=1.
- Branch after load: lw $2 followed immediately by beq $2,$0. Required: 2 stall cycles, with Z/J/JR=0 during both; then the branch resolves; stall has priority over redirect throughout.
- Boundaries:
  - Backward branch with imm=0xFFFF at NextPC_id=0x0 gives BranchAddr=0xFFFFFFFC.
  - A hazard on register 0 causes no stall.
  - Holding stall_count at 0xFFFF and stalling again leaves it at 0xFFFF.
